ifid_queue: RTL and testbench
=============================

Name: ifid_queue

Overview:
- Small instruction queue between the fetch stage and the decode stage; acts as the IF/ID boundary.
- Captures each fetched {PC, instruction, branch-predicted flag} when the instruction memory responds.
- Holds captured entries while decode is stalled and presents them to decode in order with a valid/ready handshake.
- Discards all held entries on a branch redirect (flush) and keeps a saturating count of discarded entries for performance monitoring.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h0000_0013, instruction word driven on out_instr while the queue is empty (addi x0,x0,0).
- DROP_CNT_W, 8, width of the flushed-entry counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  fetch has a valid instruction this cycle (imem response).
- in_pc  input  32  PC of the incoming instruction.
- in_instr  input  32  incoming instruction word.
- in_branch  input  1  fetch-side branching flag travelling with the instruction.
- in_ready  output  1  queue can accept an entry this cycle; fetch must hold its PC when low.
- out_valid  output  1  head entry valid for decode.
- out_pc  output  32  head PC.
- out_instr  output  32  head instruction.
- out_branch  output  1  head branching flag.
- out_ready  input  1  decode accepts the head this cycle.
- flush  input  1  redirect; discard all entries.
- count  output  clog2(DEPTH+1)  current occupancy.
- drop_cnt  output  DROP_CNT_W  saturating count of entries discarded by flush.

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, instr, branch}.
  - wr_ptr and rd_ptr are clog2(DEPTH) bits wide and wrap naturally.
  - count is tracked in a separate register.
- Handshake signals:
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready.
- Ready and valid (registered count only; no combinational path from out_ready to in_ready):
  - in_ready = !rst && (count != DEPTH).
  - out_valid = (count != 0) && !flush.
- Head data: out_pc/out_instr/out_branch = head entry when count != 0. When empty: 32'h0, NOP_INSTR, 0.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1 (baseline; see Optional Feature).
- Count update:
  - push only: count+1, wr_ptr+1.
  - pop only: count-1, rd_ptr+1.
  - push and pop together: count unchanged, both pointers advance.
- Full: in_ready=0 and in_valid is ignored, even if a pop occurs that same cycle. Space frees the following cycle.
- Empty: out_valid=0 and out_ready is ignored.
- Flush (highest priority below reset):
  - Next cycle: count=0 and rd_ptr=wr_ptr=0.
  - A same-cycle push is dropped; no pop occurs.
  - drop_cnt += count value before the flush, saturating at 2^DROP_CNT_W-1.
  - Flush while empty leaves drop_cnt unchanged.
- Reset (synchronous):
  - count=0, pointers=0, drop_cnt=0, storage contents don't-care.
  - Outputs during and after reset: out_valid=0, in_ready=0 while rst is high, out_pc=0, out_instr=NOP_INSTR, out_branch=0.
  - Reset asserted mid-operation discards all entries without incrementing drop_cnt.
- Simultaneous flush and reset: reset wins.

Optional Feature:
- Macro: IFID_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and in_valid && !flush, the input passes combinationally to out_* with out_valid=1.
  - If out_ready is also high, the entry is consumed that cycle and not written (count stays 0). Otherwise it is written as normal.
  - Zero-cycle latency when the queue is empty.
  - in_ready is unchanged (still from registered count only).
- Not defined: baseline 1-cycle latency; out_valid depends only on count and flush.

Test Plan:
- Reset, then in_valid=1 with pc 0x4000_0000, instr 0x0050_0093, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_pc=0x4000_0000, out_instr=0x0050_0093. Following cycle count=0, out_instr=0x0000_0013.
- out_ready=0; push pc 0x4000_0000, 0x4000_0004, then offer 0x4000_0008 -> count=2, in_ready=0, third entry not stored. Raise out_ready -> entries pop in order 0x...00, 0x...04.
- count=1, push and pop in the same cycle for 5 cycles with PCs incrementing by 4 -> count stays 1, each PC emitted exactly once in order, pointers wrap correctly.
- count=2 and flush=1 with in_valid=1 (pc 0x4000_0010) -> next cycle count=0, out_valid=0, drop_cnt=2, 0x4000_0010 never emitted.
- DROP_CNT_W=8: 130 flushes each with count=2 -> drop_cnt saturates at 255. Then assert rst -> drop_cnt=0, in_ready=0 during reset, 1 after.
- With IFID_QUEUE_BYPASS_EN defined: empty queue, in_valid=1 pc 0x4000_0020, out_ready=1 -> same cycle out_valid=1, out_pc=0x4000_0020, next cycle count=0. Without the macro -> out_valid=0 that cycle, 1 the next.

Source files
------------

// File: rtl/ifid_queue.sv
// IF/ID instruction queue: a small circular buffer between fetch and decode.
// Holds {pc, instr, branch} entries, presents the head to decode with a
// valid/ready handshake, drops everything on flush and keeps a saturating
// count of dropped entries.
// Optional: define IFID_QUEUE_BYPASS_EN to pass an incoming entry straight
// through to the outputs in the same cycle while the queue is empty.
module ifid_queue #(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int          DROP_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       in_branch,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_branch,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SUM_W = DROP_CNT_W + 1;

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic             r_br    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic             w_has;
  logic             w_byp;
  logic             w_push, w_pop, w_wr, w_rd;
  logic [SUM_W-1:0] w_sum;

  // Head is only meaningful out of reset; this keeps outputs clean while rst is high.
  assign w_has = !rst && (r_count != '0);

`ifdef IFID_QUEUE_BYPASS_EN
  assign w_byp = !rst && !flush && in_valid && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  // Ready comes from registered count only, so no out_ready -> in_ready path.
  assign in_ready  = !rst && (r_count != CNT_W'(DEPTH));
  assign out_valid = !rst && !flush && ((r_count != '0) || w_byp);

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready;
  // A bypassed entry consumed the same cycle never touches storage.
  assign w_wr   = w_push && !(w_byp && out_ready);
  assign w_rd   = w_pop && (r_count != '0);

  assign count    = r_count;
  assign drop_cnt = r_drop_cnt;
  assign w_sum    = SUM_W'(r_drop_cnt) + SUM_W'(r_count);

  // Head mux: stored head, bypassed input, or the idle NOP pattern.
  always_comb begin
    out_pc     = 32'h0;
    out_instr  = NOP_INSTR;
    out_branch = 1'b0;
    if (w_has) begin
      out_pc     = r_pc[r_rd_ptr];
      out_instr  = r_instr[r_rd_ptr];
      out_branch = r_br[r_rd_ptr];
    end else if (w_byp) begin
      out_pc     = in_pc;
      out_instr  = in_instr;
      out_branch = in_branch;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_pc[r_wr_ptr]    <= in_pc;
      r_instr[r_wr_ptr] <= in_instr;
      r_br[r_wr_ptr]    <= in_branch;
    end
  end

  // Pointers, occupancy and drop counter; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= w_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : w_sum[DROP_CNT_W-1:0];
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_ifid_queue.sv
// Scoreboard bench for ifid_queue: a queue model predicts every cycle's
// outputs; entries are pushed when fetch is accepted and popped on decode.
module tb_ifid_queue;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFID_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        br;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_branch, out_ready, flush;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid, out_branch;
  logic [31:0] out_pc, out_instr;
  logic [1:0]  count;
  logic [7:0]  drop_cnt;

  int   total = 0;
  int   bad   = 0;
  int   mdrop = 0;
  ent_t q[$];

  ifid_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .DROP_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_branch(in_branch),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_branch(out_branch),
    .out_ready(out_ready), .flush(flush), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic br, input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_instr = ins; in_branch = br;
    out_ready = ordy; flush = fl;
  endtask

  // Check this cycle against the model, then advance the model to the next cycle.
  task automatic mon();
    logic exp_ov, byp;
    ent_t eh;
    byp = BYP && !rst && !flush && in_valid && (q.size() == 0);
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, NOP);
      chk("rst_out_branch", out_branch, 0);
      q.delete();
      mdrop = 0;
    end else begin
      chk("count", count, q.size());
      chk("drop_cnt", drop_cnt, mdrop);
      chk("in_ready", in_ready, q.size() != DEPTH);
      exp_ov = !flush && (q.size() != 0 || byp);
      chk("out_valid", out_valid, exp_ov);
      if (q.size() != 0) eh = q[0];
      else if (byp)      eh = '{pc: in_pc, instr: in_instr, br: in_branch};
      else               eh = '{pc: 32'h0, instr: NOP, br: 1'b0};
      chk("out_pc", out_pc, eh.pc);
      chk("out_instr", out_instr, eh.instr);
      chk("out_branch", out_branch, eh.br);
      if (flush) begin
        mdrop = mdrop + q.size();
        if (mdrop > 255) mdrop = 255;
        q.delete();
      end else begin
        if (in_valid && q.size() != DEPTH)
          q.push_back('{pc: in_pc, instr: in_instr, br: in_branch});
        if (exp_ov && out_ready) void'(q.pop_front());
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    step();

    // Single instruction through an empty queue.
    drive(1, 32'h4000_0000, 32'h0050_0093, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    #1 chk("lat_ov", out_valid, !BYP);
    step(); step();
    chk("empty_instr", out_instr, NOP);

    // Fill to full with decode stalled, offer a third, then drain.
    drive(1, 32'h4000_0000, 32'h1, 1, 0, 0); step();
    drive(1, 32'h4000_0004, 32'h2, 0, 0, 0); step();
    drive(1, 32'h4000_0008, 32'h3, 1, 0, 0); step();
    chk("full_count", count, 2);
    chk("full_in_ready", in_ready, 0);
    drive(0, 0, 0, 0, 1, 0);
    step(); step(); step();

    // Steady push+pop at occupancy 1, pointers wrap.
    drive(1, 32'h4000_0100, 32'h10, 0, 0, 0); step();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 32'h4000_0100 + 32'(4*i), 32'h10 + 32'(i), i[0], 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 0); step(); step();

    // Flush while full with a same-cycle push.
    drive(1, 32'h4000_0000, 32'h20, 0, 0, 0); step();
    drive(1, 32'h4000_0004, 32'h21, 0, 0, 0); step();
    drive(1, 32'h4000_0010, 32'h22, 0, 0, 1); step();
    drive(0, 0, 0, 0, 1, 0);
    chk("flush_count", count, 0);
    chk("flush_drop", drop_cnt, 2);
    step(); step();

    // Saturate the drop counter.
    for (int i = 0; i < 130; i++) begin
      drive(1, 32'h5000_0000, 32'h30, 0, 0, 0); step();
      drive(1, 32'h5000_0004, 32'h31, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 1); step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("drop_sat", drop_cnt, 255);
    step();

    // Reset mid-operation with an entry held.
    drive(1, 32'h6000_0000, 32'h40, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1 chk("rst_ready_low", in_ready, 0);
    step(); step();
    rst = 1'b0;
    #1 chk("post_rst_ready", in_ready, 1);
    chk("post_rst_drop", drop_cnt, 0);
    chk("post_rst_count", count, 0);
    step();

    // Empty-queue latency (bypass vs registered path).
    drive(1, 32'h4000_0020, 32'h50, 1, 1, 0);
    #1 chk("byp_ov", out_valid, BYP);
    step();
    drive(0, 0, 0, 0, 1, 0);
    #1 chk("byp_next_ov", out_valid, !BYP);
    step(); step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) != 0, 32'h7000_0000 + 32'(4*i), $urandom, 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 0);
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
